// File: rtl/palindrome_gen.sv
`default_nettype none
// ============================================================================
// Module      : palindrome_gen
// Description : Sequential generator that streams every WIDTH-bit binary
//               palindrome in strictly ascending order over a valid/ready
//               handshake, one value per accepted beat, after a start pulse.
//               Optional feature macro PAL_GEN_MSB_SET_EN: when defined, the
//               sweep starts at half-word 2^(H-1), so only palindromes with
//               MSB=1 (and therefore LSB=1) are produced.
// Revision    : 1.0 - initial release
// ============================================================================
module palindrome_gen #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [(WIDTH+1)/2-1:0] out_index,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  // Half width: the free bits that fully determine a palindrome.
  localparam int H = (WIDTH + 1) / 2;

  localparam logic [H-1:0] H_MAX = {H{1'b1}};
  localparam logic [H-1:0] H_ONE = H'(1);

`ifdef PAL_GEN_MSB_SET_EN
  // Only the top half-word bit set: the first palindrome with MSB=1.
  localparam logic [H-1:0] H_START = H_MAX ^ (H_MAX >> 1);
`else
  localparam logic [H-1:0] H_START = '0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [H-1:0] h_q, h_d;
  logic         accept;

  assign accept = (state_q == S_RUN) && out_ready;

  // State and half-word registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
    end
  end

  // Next-state and half-word update; abort beats a simultaneous accept.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          h_d     = H_START;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept) begin
          if (h_q == H_MAX) begin
            state_d = S_DONE;
          end else begin
            h_d = h_q + H_ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded purely from registered state.
  always_comb begin
    out_valid = (state_q == S_RUN);
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    out_last  = (state_q == S_RUN) && (h_q == H_MAX);
    out_index = h_q;
  end

  // Upper H bits carry h directly; the lower WIDTH-H bits mirror h from its
  // MSB downward. For odd WIDTH the middle bit belongs to the upper half only,
  // so h[0] is not repeated in the low part.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mirror
    if (i >= WIDTH - H) begin : g_hi
      assign out_data[i] = h_q[i-(WIDTH-H)];
    end else begin : g_lo
      assign out_data[i] = h_q[H-1-i];
    end
  end

endmodule
`default_nettype wire
